// File: rtl/trail_plotter.sv
// Lightbike framebuffer writer: full-screen clear and read-check-write head plots.
// Option TRAIL_PLOTTER_SELF_OVERWRITE_EN: a bike may repaint a pixel already holding its own colour.
module trail_plotter #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int IDX_W  = 8,
  parameter int BG_IDX = 0
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              clear_start,
  output logic              busy,
  input  logic              plot_valid,
  output logic              plot_ready,
  input  logic [9:0]        plot_x,
  input  logic [8:0]        plot_y,
  input  logic [IDX_W-1:0]  plot_idx,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_we,
  output logic [IDX_W-1:0]  fb_wdata,
  input  logic [IDX_W-1:0]  fb_rdata,
  output logic              done,
  output logic              collision,
  output logic              coll_wall,
  output logic [IDX_W-1:0]  coll_idx
);

  localparam logic [9:0]        HMAX = 10'(H_RES);
  localparam logic [8:0]        VMAX = 9'(V_RES);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [IDX_W-1:0]  BG   = IDX_W'(BG_IDX);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RD,
    CHK
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [IDX_W-1:0]    r_idx;
  logic                r_done;
  logic                r_coll;
  logic                r_wall;
  logic [IDX_W-1:0]    r_cidx;

  logic                w_accept;
  logic                w_off;
  logic                w_empty;
  logic [ADDR_W-1:0]   w_addr;

  assign w_accept = plot_valid & plot_ready;
  assign w_off    = (plot_x >= HMAX) | (plot_y >= VMAX);
  assign w_addr   = ADDR_W'(plot_y) * ADDR_W'(H_RES)
                  + ADDR_W'(plot_x);

`ifdef TRAIL_PLOTTER_SELF_OVERWRITE_EN
  assign w_empty = (fb_rdata == BG) | (fb_rdata == r_idx);
`else
  assign w_empty = (fb_rdata == BG);
`endif

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_coll  <= 1'b0;
      r_wall  <= 1'b0;
      r_cidx  <= '0;
    end else begin
      r_done <= 1'b0;
      r_coll <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clear_start) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
          end else if (w_accept) begin
            // off-screen heads never touch memory
            if (w_off) begin
              r_done <= 1'b1;
              r_coll <= 1'b1;
              r_wall <= 1'b1;
              r_cidx <= BG;
            end else begin
              r_addr  <= w_addr;
              r_idx   <= plot_idx;
              r_state <= RD;
            end
          end
        end
        CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
            r_wall  <= 1'b0;
            r_cidx  <= BG;
          end
        end
        RD: r_state <= CHK;
        CHK: begin
          r_state <= IDLE;
          r_done  <= 1'b1;
          r_wall  <= 1'b0;
          if (w_empty) begin
            r_cidx <= BG;
          end else begin
            r_coll <= 1'b1;
            r_cidx <= fb_rdata;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // clear_start wins over a same-cycle plot request
  assign plot_ready = (r_state == IDLE) & ~clear_start & ~reset;
  assign busy       = (r_state != IDLE);
  assign fb_we      = ~reset & ((r_state == CLEAR)
                    | ((r_state == CHK) & w_empty));
  assign fb_addr    = (r_state == CLEAR) ? r_cnt : r_addr;
  assign fb_wdata   = (r_state == CLEAR) ? BG : r_idx;
  assign done       = r_done;
  assign collision  = r_coll;
  assign coll_wall  = r_wall;
  assign coll_idx   = r_cidx;

endmodule

// File: tb/tb_trail_plotter.sv
// Randomised self-checking bench for trail_plotter against a pixel-array model.
// Uses a reduced 640x48 screen so a full clear stays short.
module tb_trail_plotter;

  localparam int H = 640;
  localparam int V = 48;
  localparam int N = H * V;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_start;
  logic        busy;
  logic        plot_valid;
  logic        plot_ready;
  logic [9:0]  plot_x;
  logic [8:0]  plot_y;
  logic [7:0]  plot_idx;
  logic [18:0] fb_addr;
  logic        fb_we;
  logic [7:0]  fb_wdata;
  logic [7:0]  fb_rdata;
  logic        done;
  logic        collision;
  logic        coll_wall;
  logic [7:0]  coll_idx;

  logic [7:0]  ram    [N];
  logic [7:0]  ref_fb [N];

  int n_checks = 0;
  int n_fail   = 0;

  logic       pend = 1'b0;
  logic       pend_coll;
  logic       pend_wall;
  logic [7:0] pend_cidx;

  always #5 clk = ~clk;

  trail_plotter #(
    .H_RES (H),
    .V_RES (V),
    .ADDR_W(19),
    .IDX_W (8),
    .BG_IDX(0)
  ) dut (
    .vga_clk    (clk),
    .reset      (reset),
    .clear_start(clear_start),
    .busy       (busy),
    .plot_valid (plot_valid),
    .plot_ready (plot_ready),
    .plot_x     (plot_x),
    .plot_y     (plot_y),
    .plot_idx   (plot_idx),
    .fb_addr    (fb_addr),
    .fb_we      (fb_we),
    .fb_wdata   (fb_wdata),
    .fb_rdata   (fb_rdata),
    .done       (done),
    .collision  (collision),
    .coll_wall  (coll_wall),
    .coll_idx   (coll_idx)
  );

  // synchronous-read framebuffer
  always @(posedge clk) begin
    if (fb_we && int'(fb_addr) < N) ram[int'(fb_addr)] <= fb_wdata;
    fb_rdata <= (int'(fb_addr) < N) ? ram[int'(fb_addr)] : 8'hEE;
  end

  task automatic idle_cycle();
    @(negedge clk);
    clear_start = 1'b0;
    plot_valid  = 1'b0;
    #1;
    n_checks++;
    if (done !== pend)
      $display("FAIL done_slot: done=%b expected %b", done, pend);
    if (pend) begin
      n_checks++;
      if (collision !== pend_coll)
        $display("FAIL coll_flag: collision=%b expected %b", collision, pend_coll);
      if (pend_coll) begin
        n_checks++;
        if (coll_wall !== pend_wall || coll_idx !== pend_cidx)
          $display("FAIL coll_info: wall=%b idx=%0d expected wall=%b idx=%0d",
                   coll_wall, coll_idx, pend_wall, pend_cidx);
      end
    end
    if (done !== pend || (pend && collision !== pend_coll)) n_fail++;
    else if (pend && pend_coll && (coll_wall !== pend_wall || coll_idx !== pend_cidx)) n_fail++;
    pend = 1'b0;
  endtask

  task automatic do_plot(input int x, input int y, input int idx);
    logic       off;
    logic       empty;
    int         a;
    logic [7:0] cur;
    logic [7:0] pi;
    pi    = idx[7:0];
    off   = (x >= H) || (y >= V);
    a     = off ? 0 : y * H + x;
    cur   = off ? 8'd0 : ref_fb[a];
    empty = !off && (cur == 8'd0);
`ifdef TRAIL_PLOTTER_SELF_OVERWRITE_EN
    if (!off && cur == pi) empty = 1'b1;
`endif
    @(negedge clk);
    clear_start = 1'b0;
    plot_valid  = 1'b1;
    plot_x      = x[9:0];
    plot_y      = y[8:0];
    plot_idx    = pi;
    #1;
    n_checks++;
    if (done !== pend) begin
      n_fail++;
      $display("FAIL done_slot: done=%b expected %b", done, pend);
    end
    if (pend) begin
      n_checks++;
      if (collision !== pend_coll) begin
        n_fail++;
        $display("FAIL coll_flag: collision=%b expected %b", collision, pend_coll);
      end
      if (pend_coll) begin
        n_checks++;
        if (coll_wall !== pend_wall || coll_idx !== pend_cidx) begin
          n_fail++;
          $display("FAIL coll_info: wall=%b idx=%0d expected wall=%b idx=%0d",
                   coll_wall, coll_idx, pend_wall, pend_cidx);
        end
      end
    end
    n_checks++;
    if (plot_ready !== 1'b1 || fb_we !== 1'b0) begin
      n_fail++;
      $display("FAIL accept: ready=%b we=%b expected ready=1 we=0", plot_ready, fb_we);
    end
    if (!off) begin
      @(negedge clk);
      plot_valid = 1'b0;
      plot_x     = 10'($urandom);
      plot_y     = 9'($urandom);
      plot_idx   = 8'($urandom);
      #1;
      n_checks++;
      if (fb_we !== 1'b0 || fb_addr !== a[18:0] || done !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_cycle (%0d,%0d): we=%b addr=%0d done=%b expected we=0 addr=%0d done=0",
                 x, y, fb_we, fb_addr, done, a);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (fb_we !== empty || fb_addr !== a[18:0] || done !== 1'b0) begin
        n_fail++;
        $display("FAIL chk_cycle (%0d,%0d): we=%b addr=%0d done=%b expected we=%b addr=%0d done=0",
                 x, y, fb_we, fb_addr, done, empty, a);
      end
      if (empty) begin
        n_checks++;
        if (fb_wdata !== pi) begin
          n_fail++;
          $display("FAIL wdata: %0d expected %0d", fb_wdata, pi);
        end
        ref_fb[a] = pi;
      end
    end
    pend      = 1'b1;
    pend_coll = off || !empty;
    pend_wall = off;
    pend_cidx = off ? 8'd0 : cur;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    clear_start = 1'b0;
    plot_valid  = 1'b0;
    plot_x      = '0;
    plot_y      = '0;
    plot_idx    = '0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (fb_we !== 1'b0 || plot_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: we=%b ready=%b expected 0 0", fb_we, plot_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (done !== 0 || collision !== 0 || coll_wall !== 0 || coll_idx !== 0 ||
        fb_we !== 0 || fb_addr !== 0 || fb_wdata !== 0 || busy !== 0 ||
        plot_ready !== 1) begin
      n_fail++;
      $display("FAIL reset_state: done=%b coll=%b wall=%b cidx=%0d we=%b addr=%0d wd=%0d busy=%b ready=%b expected all 0 and ready=1",
               done, collision, coll_wall, coll_idx, fb_we, fb_addr, fb_wdata, busy, plot_ready);
    end
  endtask

  task automatic test_clear();
    int exp_a;
    int wecnt;
    int aerr;
    int rerr;
    int done_k;
    logic coll_d;
    idle_cycle();
    @(negedge clk);
    clear_start = 1'b1;
    plot_valid  = 1'b1;
    plot_x      = 10'd3;
    plot_y      = 9'd1;
    plot_idx    = 8'd9;
    #1;
    n_checks++;
    if (fb_we !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_start_we: we=%b expected 0", fb_we);
    end
    exp_a  = 0;
    wecnt  = 0;
    aerr   = 0;
    rerr   = 0;
    done_k = -1;
    coll_d = 1'b0;
    for (int k = 1; k <= N + 20 && done_k < 0; k++) begin
      @(negedge clk);
      clear_start = (k == 500);
      plot_valid  = (k < N);
      #1;
      if (done === 1'b1) begin
        done_k = k;
        coll_d = collision;
      end else begin
        if (plot_ready !== 1'b0) rerr++;
        if (fb_we === 1'b1) begin
          if (fb_addr !== exp_a[18:0] || fb_wdata !== 8'd0) aerr++;
          exp_a++;
          wecnt++;
        end else aerr++;
      end
    end
    n_checks++;
    if (wecnt !== N) begin
      n_fail++;
      $display("FAIL clear_writes: %0d expected %0d", wecnt, N);
    end
    n_checks++;
    if (aerr !== 0) begin
      n_fail++;
      $display("FAIL clear_seq: %0d bad cycles expected 0", aerr);
    end
    n_checks++;
    if (rerr !== 0) begin
      n_fail++;
      $display("FAIL clear_ready: ready high %0d cycles expected 0", rerr);
    end
    n_checks++;
    if (done_k !== N + 1 || coll_d !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_done: done at %0d coll=%b expected %0d coll=0", done_k, coll_d, N + 1);
    end
    @(negedge clk);
    plot_valid  = 1'b0;
    clear_start = 1'b0;
    #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_after: done=%b busy=%b expected 0 0", done, busy);
    end
    for (int i = 0; i < N; i++) ref_fb[i] = 8'd0;
  endtask

  task automatic test_plot_basic();
    do_plot(10, 2, 5);
    do_plot(10, 2, 5);
    idle_cycle();
  endtask

  task automatic test_wall();
    do_plot(640, 0, 7);
    do_plot(0, V, 7);
    do_plot(1023, 511, 7);
    idle_cycle();
  endtask

  task automatic test_corner();
    do_plot(H - 1, V - 1, 3);
    do_plot(H - 1, V - 1, 4);
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    do_plot(20, 5, 1);
    do_plot(21, 5, 1);
    do_plot(H, 5, 1);
    do_plot(20, 5, 2);
    do_plot(0, 0, 6);
    do_plot(21, 5, 1);
    idle_cycle();
  endtask

  task automatic test_random();
    int r;
    int x;
    int y;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      r = int'($urandom_range(0, 9));
      x = int'($urandom_range(0, 7));
      y = int'($urandom_range(0, 3));
      if (r == 0) x = int'($urandom_range(H, 1023));
      if (r == 1) y = int'($urandom_range(V, 511));
      if (r == 2) begin
        x = int'($urandom_range(H - 3, H - 1));
        y = int'($urandom_range(V - 2, V - 1));
      end
      do_plot(x, y, int'($urandom_range(0, 4)));
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid_clear();
    int hit;
    int derr;
    do_plot(360, 1, 6);
    idle_cycle();
    @(negedge clk);
    clear_start = 1'b1;
    #1;
    hit = 0;
    for (int k = 0; k < 1100 && hit == 0; k++) begin
      @(negedge clk);
      clear_start = 1'b0;
      #1;
      if (fb_we === 1'b1 && fb_addr === 19'd999) hit = 1;
    end
    n_checks++;
    if (hit == 0) begin
      n_fail++;
      $display("FAIL mid_clear_reach: addr 999 never written");
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (fb_we !== 1'b0 || plot_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_clear_rst: we=%b ready=%b expected 0 0", fb_we, plot_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (fb_we !== 1'b0 || busy !== 1'b0 || fb_addr !== 0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_clear_after: we=%b busy=%b addr=%0d done=%b expected 0 0 0 0",
               fb_we, busy, fb_addr, done);
    end
    derr = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (done !== 1'b0 || fb_we !== 1'b0) derr++;
    end
    n_checks++;
    if (derr !== 0) begin
      n_fail++;
      $display("FAIL mid_clear_quiet: %0d active cycles expected 0", derr);
    end
    for (int i = 0; i < 1000; i++) ref_fb[i] = 8'd0;
    do_plot(5, 0, 9);
    do_plot(360, 1, 2);
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_clear();
    test_plot_basic();
    test_wall();
    test_corner();
    test_back_to_back();
    test_random();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trail_plotter.md
Name: trail_plotter

Overview:
Upstream neighbour of the VGA controller in the lightbike design. Owns the write side of the 640x480 8-bit colour-index framebuffer that the controller scans out.
- Clears the framebuffer on request.
- Accepts one bike-head plot request at a time.
- Read-checks the target pixel: empty → writes the bike's colour index; occupied or off-screen → reports a collision to game logic.

Parameters:
H_RES, 640, visible pixels per line
V_RES, 480, visible lines per frame
ADDR_W, 19, framebuffer address width (H_RES*V_RES must fit)
IDX_W, 8, colour-index width (matches palette ROM address)
BG_IDX, 0, colour index meaning empty/background

Ports:
vga_clk  in  1  single clock, same domain as framebuffer write port
reset  in  1  synchronous, active-high
clear_start  in  1  one-cycle pulse: fill the whole framebuffer with BG_IDX
busy  out  1  high while not in IDLE
plot_valid  in  1  plot request valid
plot_ready  out  1  plot request accepted when plot_valid & plot_ready
plot_x  in  10  head x coordinate
plot_y  in  9  head y coordinate
plot_idx  in  IDX_W  bike colour index to paint
fb_addr  out  ADDR_W  framebuffer address (shared read/write)
fb_we  out  1  framebuffer write enable
fb_wdata  out  IDX_W  framebuffer write data
fb_rdata  in  IDX_W  framebuffer read data, valid 1 cycle after fb_addr (synchronous RAM)
done  out  1  one-cycle pulse: plot or clear finished
collision  out  1  one-cycle pulse, coincident with done, plot hit something
coll_wall  out  1  qualifies collision: 1 = off-screen, 0 = occupied pixel
coll_idx  out  IDX_W  colour index found at the hit pixel (BG_IDX for wall hits)

Behaviour:
- States: IDLE, CLEAR, RD, CHK. fb_* outputs, plot_ready and busy are decoded from registered state and datapath regs.
- Reset, synchronous, in any state including mid-clear or mid-plot:
  - state → IDLE; no write completes.
  - done, collision, coll_wall, coll_idx → 0.
  - fb_we = 0 and plot_ready = 0 during the reset cycle.
  - fb_addr and fb_wdata → 0.
- IDLE:
  - plot_ready = 1, busy = 0, fb_we = 0.
  - clear_start has priority over plot_valid in the same cycle.
  - clear_start → CLEAR, clear counter = 0.
  - else plot_valid (handshake) → capture x, y, idx into regs.
  - Address computed in the accept cycle: addr = y*640 + x = (y<<9)+(y<<7)+x, evaluated at ADDR_W bits (no overflow for legal coords).
  - If x ≥ H_RES or y ≥ V_RES: stay IDLE; next cycle done = collision = coll_wall = 1, coll_idx = BG_IDX; no memory access.
  - Else → RD.
- RD: fb_addr = addr, fb_we = 0, plot_ready = 0 → CHK.
- CHK: fb_addr = addr; fb_rdata is valid in this cycle.
  - fb_rdata == BG_IDX: fb_we = 1, fb_wdata = idx.
  - Otherwise: fb_we = 0, and next cycle collision = 1, coll_wall = 0, coll_idx = fb_rdata.
  - Either way → IDLE, and next cycle done = 1.
- Latency and throughput:
  - Plot: accept edge → done pulse 3 cycles later.
  - Maximum rate is one plot per 3 cycles.
  - A new request may be accepted in the same cycle done pulses.
- CLEAR:
  - Each cycle: fb_we = 1, fb_wdata = BG_IDX, fb_addr = counter; counter += 1.
  - Last write at H_RES*V_RES-1 (307199), then → IDLE; done pulses the next cycle with collision = 0.
  - Total duration is 307200 write cycles.
  - clear_start during CLEAR is ignored (no restart).
  - plot_valid is held off (plot_ready = 0).
- done and collision are registered single-cycle pulses.
- coll_wall and coll_idx hold their values until the next done.
- Never write while reading the same plot: exactly one fb_we cycle per successful plot.

Optional Feature:
Macro: TRAIL_PLOTTER_SELF_OVERWRITE_EN
- Defined: in CHK, fb_rdata == plot idx also counts as empty. The write is performed with no collision, so a bike may repaint its own head pixel.
- Not defined: any non-BG_IDX value is a collision, including the bike's own colour.

Test Plan:
- Reset then clear_start pulse:
  - fb_we high for exactly 307200 consecutive cycles.
  - fb_addr runs 0..307199 with fb_wdata = 0.
  - Then a single done, collision = 0; busy low afterwards.
- After clear, plot (x=10, y=2, idx=5):
  - fb_addr = 1290; fb_we = 1 with wdata = 5 in the CHK cycle.
  - done 3 cycles after accept, collision = 0.
- Repeat the same plot with fb_rdata model returning 5:
  - No fb_we.
  - collision = 1, coll_wall = 0, coll_idx = 5.
  - With TRAIL_PLOTTER_SELF_OVERWRITE_EN: write occurs, collision = 0.
- Plot (x=640, y=0) and plot (x=0, y=480):
  - No fb access.
  - done and collision = 1 next cycle with coll_wall = 1.
- Plot (x=639, y=479, idx=3): fb_addr = 307199, write performed.
- Corner cases:
  - clear_start and plot_valid together in IDLE → clear wins and plot_ready stays 0 until clear completes.
  - reset asserted mid-clear at counter = 1000 → fb_we = 0 next cycle, IDLE, no done.
